// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - ALU op encoding package and ALU request/response interface
package alu_issue_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;
endpackage

interface alu_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0]  operand1;
    logic [DATA_WIDTH-1:0]  operand2;
    alu_issue_pkg::alu_op_t alu_op;
    logic                   req_valid;
    logic [DATA_WIDTH-1:0]  result;
    logic                   resp_valid;

    modport requester (
        output operand1, operand2, alu_op, req_valid,
        input  result, resp_valid
    );

    modport responder (
        input  operand1, operand2, alu_op, req_valid,
        output result, resp_valid
    );

    modport master (
        output operand1, operand2, alu_op, req_valid,
        input  result, resp_valid
    );

    modport slave (
        input  operand1, operand2, alu_op, req_valid,
        output result, resp_valid
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - execute-stage issue controller for a multi-cycle ALU (optional watchdog: ALU_ISSUE_TIMEOUT_EN)
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  alu_op_t                   in_alu_op,
    input  logic [DATA_WIDTH-1:0]     in_rs1,
    input  logic [DATA_WIDTH-1:0]     in_rs2,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic                      in_op1_pc,
    input  logic                      in_op2_imm,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_rd_we,
    alu_if.requester                  alu,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      wb_rd_we,
    output logic                      err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t                    state_q,     state_d;
    logic                      req_valid_q, req_valid_d;
    logic [DATA_WIDTH-1:0]     op1_q,       op1_d;
    logic [DATA_WIDTH-1:0]     op2_q,       op2_d;
    alu_op_t                   alu_op_q,    alu_op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
    logic                      rd_we_q,     rd_we_d;
    logic                      wb_valid_q,  wb_valid_d;
    logic [DATA_WIDTH-1:0]     wb_data_q,   wb_data_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q,     wb_rd_d;
    logic                      wb_rd_we_q,  wb_rd_we_d;
    logic                      accept;

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;

    assign timeout     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;
`else
    // Watchdog disabled: WAIT/DRAIN wait for the ALU indefinitely.
    wire unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign err_timeout = 1'b0;
`endif

    // HOLD can hand its slot to the next op on the same edge the result is consumed
    always_comb begin
        in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && wb_ready);
        accept   = in_valid && in_ready && !flush;
    end

    // Next-state, operand latch and writeback buffer updates
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_rd_we_d  = wb_rd_we_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
            end
            S_WAIT: begin
                if (alu.resp_valid) begin
                    req_valid_d = 1'b0;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu.result;
                        wb_rd_d    = rd_q;
                        wb_rd_we_d = rd_we_q;
                        state_d    = S_HOLD;
                    end
                end else if (flush) begin
                    // The ALU cannot abort, so keep the request up until it answers
                    state_d = S_DRAIN;
`ifdef ALU_ISSUE_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (timeout) begin
                    req_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            S_HOLD: begin
                if (flush || wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (alu.resp_valid) begin
                    req_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef ALU_ISSUE_TIMEOUT_EN
                end else if (timeout) begin
                    req_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            op1_d       = in_op1_pc  ? in_pc  : in_rs1;
            op2_d       = in_op2_imm ? in_imm : in_rs2;
            alu_op_d    = in_alu_op;
            rd_d        = in_rd;
            rd_we_d     = in_rd_we && (in_rd != '0);
            req_valid_d = 1'b1;
            state_d     = S_WAIT;
`ifdef ALU_ISSUE_TIMEOUT_EN
            cnt_d       = '0;
`endif
        end
    end

    // State and output registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            alu_op_q    <= ALU_ADD;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_rd_we_q  <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_rd_we_q  <= wb_rd_we_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign alu.operand1  = op1_q;
    assign alu.operand2  = op2_q;
    assign alu.alu_op    = alu_op_q;
    assign alu.req_valid = req_valid_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_rd_we      = wb_rd_we_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized bench with transaction-level reference model for alu_issue_ctrl
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 64;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    alu_op_t       in_alu_op = ALU_ADD;
    logic [DW-1:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
    logic          in_op1_pc = 1'b0, in_op2_imm = 1'b0;
    logic [RW-1:0] in_rd = '0;
    logic          in_rd_we = 1'b0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;
    logic          wb_rd_we;
    logic          err_timeout;

    alu_if #(.DATA_WIDTH(DW)) alu_bus ();

    alu_issue_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_op1_pc(in_op1_pc), .in_op2_imm(in_op2_imm), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .alu(alu_bus),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_rd_we(wb_rd_we), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] alu_fn(input alu_op_t op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: return {{(DW-1){1'b0}}, a < b};
            default:  return '0;
        endcase
    endfunction

    // Reference model: one op may be outstanding at the ALU, one result may wait for writeback
    bit            m_busy, m_killed, m_res;
    logic [DW-1:0] m_op1, m_op2, m_res_data;
    alu_op_t       m_op;
    logic [RW-1:0] m_rd, m_res_rd;
    bit            m_we, m_res_we;

    // ALU stub state
    bit            s_pend, s_mute;
    int            s_wait, s_lat_min, s_lat_max;
    bit            cmp_en = 1'b1;

    task automatic model_clear();
        m_busy = 0; m_killed = 0; m_res = 0;
        m_op1 = '0; m_op2 = '0; m_op = ALU_ADD; m_rd = '0; m_we = 0;
        m_res_data = '0; m_res_rd = '0; m_res_we = 0;
        s_pend = 0;
    endtask

    // One clock: stub response, per-cycle compare, model update; called at a falling edge
    task automatic step();
        bit exp_ready, acc, old_res;
        if (!rst_n) model_clear();
        alu_bus.resp_valid = 1'b0;
        alu_bus.result     = $urandom;
        if (rst_n && alu_bus.req_valid) begin
            if (!s_pend) begin
                s_pend = 1;
                s_wait = $urandom_range(s_lat_max, s_lat_min);
            end
            if (s_wait == 0 && !s_mute) begin
                alu_bus.resp_valid = 1'b1;
                alu_bus.result     = alu_fn(alu_bus.alu_op, alu_bus.operand1, alu_bus.operand2);
                s_pend = 0;
            end else begin
                s_wait--;
            end
        end
        #1;
        exp_ready = !m_busy && (!m_res || wb_ready);
        if (cmp_en) begin
            chk("in_ready", in_ready, exp_ready);
            chk("req_valid", alu_bus.req_valid, m_busy);
            chk("wb_valid", wb_valid, m_res);
            chk("err_timeout", err_timeout, 0);
            if (m_busy) begin
                chk("operand1", alu_bus.operand1, m_op1);
                chk("operand2", alu_bus.operand2, m_op2);
                chk("alu_op", alu_bus.alu_op, m_op);
            end
            if (m_res) begin
                chk("wb_data", wb_data, m_res_data);
                chk("wb_rd", wb_rd, m_res_rd);
                chk("wb_rd_we", wb_rd_we, m_res_we);
            end
        end
        if (rst_n) begin
            acc     = in_valid && exp_ready && !flush;
            old_res = m_res;
            if (m_busy && alu_bus.resp_valid) begin
                m_busy = 0;
                if (!m_killed && !flush) begin
                    m_res      = 1;
                    m_res_data = alu_fn(m_op, m_op1, m_op2);
                    m_res_rd   = m_rd;
                    m_res_we   = m_we;
                end
                m_killed = 0;
            end else if (m_busy && flush) begin
                m_killed = 1;
            end
            if (old_res && (flush || wb_ready)) m_res = 0;
            if (acc) begin
                m_busy   = 1;
                m_killed = 0;
                m_op1    = in_op1_pc  ? in_pc  : in_rs1;
                m_op2    = in_op2_imm ? in_imm : in_rs2;
                m_op     = in_alu_op;
                m_rd     = in_rd;
                m_we     = in_rd_we && (in_rd != 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_op(input alu_op_t op, input logic [DW-1:0] rs1, input logic [DW-1:0] rs2,
                          input logic [DW-1:0] pc, input logic [DW-1:0] imm, input bit op1pc,
                          input bit op2imm, input logic [RW-1:0] rd, input bit we);
        in_valid = 1; in_alu_op = op; in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm;
        in_op1_pc = op1pc; in_op2_imm = op2imm; in_rd = rd; in_rd_we = we;
    endtask

    task automatic run_until_wb(input int limit, output int req_cycles, output bit seen);
        req_cycles = 0;
        seen       = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (alu_bus.req_valid) req_cycles++;
            if (wb_valid) seen = 1;
        end
    endtask

    initial begin
        int  rc;
        bit  seen, bad;
        alu_bus.resp_valid = 1'b0;
        alu_bus.result     = '0;
        s_mute = 0; s_lat_min = 0; s_lat_max = 4;
        model_clear();
        @(negedge clk);

        // Reset values
        step();
        chk("rst_req_valid", alu_bus.req_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd_we", wb_rd_we, 0);
        chk("rst_operand1", alu_bus.operand1, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1;
        step();

        // flush in IDLE blocks the accept
        set_op(ALU_ADD, 1, 2, 0, 0, 0, 0, 1, 1);
        flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("idle_flush_no_issue", alu_bus.req_valid, 0);

        // ADD 5+7 -> rd 3, fixed ALU latency of 2
        s_lat_min = 2; s_lat_max = 2;
        set_op(ALU_ADD, 5, 7, 32'h40, 32'h99, 0, 0, 3, 1);
        step();
        in_valid = 0;
        chk("add_req_after_accept", alu_bus.req_valid, 1);
        run_until_wb(20, rc, seen);
        chk("add_wb_seen", seen, 1);
        chk("add_req_cycles", rc, 2);
        chk("add_wb_data", wb_data, 12);
        chk("add_wb_rd", wb_rd, 3);
        chk("add_wb_rd_we", wb_rd_we, 1);

        // Result held for 5 cycles while decode already offers the next op
        set_op(ALU_SUB, 32'h7, 32'h3, 32'h100, 32'h10, 1, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_wb_data", wb_data, 12);
            chk("hold_wb_valid", wb_valid, 1);
            chk("hold_no_req", alu_bus.req_valid, 0);
            chk("hold_in_ready", in_ready, 0);
        end
        wb_ready = 1;
        step();
        in_valid = 0; wb_ready = 0;
        chk("b2b_issue", alu_bus.req_valid, 1);
        chk("b2b_wb_drop", wb_valid, 0);
        run_until_wb(20, rc, seen);
        chk("sub_wb_seen", seen, 1);
        chk("sub_wb_data", wb_data, 32'hF0);
        chk("sub_wb_rd", wb_rd, 0);
        chk("sub_wb_rd_we", wb_rd_we, 0);
        wb_ready = 1;
        step();
        wb_ready = 0;
        chk("sub_wb_consumed", wb_valid, 0);

        // flush 3 cycles after issue: result must be discarded
        s_lat_min = 6; s_lat_max = 6;
        set_op(ALU_XOR, 32'hFF, 32'h0F, 0, 0, 0, 0, 9, 1);
        step();
        in_valid = 0;
        step();
        step();
        flush = 1;
        step();
        flush = 0;
        chk("drain_req_held", alu_bus.req_valid, 1);
        chk("drain_in_ready", in_ready, 0);
        bad = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (wb_valid) bad = 1;
            if (!alu_bus.req_valid) seen = 1;
        end
        chk("drain_done", seen, 1);
        chk("drain_no_wb", bad, 0);
        chk("drain_idle_ready", in_ready, 1);

        // Reset in the middle of an op
        s_lat_min = 3; s_lat_max = 3;
        set_op(ALU_OR, 1, 2, 0, 0, 0, 0, 4, 1);
        step();
        in_valid = 0;
        rst_n = 0;
        step();
        chk("midrst_req_valid", alu_bus.req_valid, 0);
        chk("midrst_wb_valid", wb_valid, 0);
        rst_n = 1;
        step();

        // Randomized traffic
        s_lat_min = 0; s_lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(99, 0) < 60);
            in_alu_op  = alu_op_t'($urandom_range(9, 0));
            in_rs1     = $urandom;
            in_rs2     = $urandom;
            in_pc      = $urandom;
            in_imm     = $urandom;
            in_op1_pc  = $urandom_range(1, 0);
            in_op2_imm = $urandom_range(1, 0);
            in_rd      = RW'($urandom_range(31, 0));
            in_rd_we   = $urandom_range(1, 0);
            flush      = ($urandom_range(99, 0) < 5);
            wb_ready   = ($urandom_range(99, 0) < 60);
            step();
        end
        in_valid = 0; flush = 0; wb_ready = 1;
        for (int i = 0; i < 10; i++) step();

`ifdef ALU_ISSUE_TIMEOUT_EN
        // Silent ALU: watchdog drops the op after TO request cycles
        cmp_en = 0;
        s_mute = 1;
        set_op(ALU_ADD, 1, 1, 0, 0, 0, 0, 2, 1);
        step();
        in_valid = 0;
        rc = 0;
        seen = 0;
        for (int i = 0; i < 3 * TO && !seen; i++) begin
            if (alu_bus.req_valid) rc++;
            step();
            if (err_timeout) seen = 1;
        end
        chk("to_pulse_seen", seen, 1);
        chk("to_req_cycles", rc, TO);
        chk("to_req_dropped", alu_bus.req_valid, 0);
        chk("to_idle_ready", in_ready, 1);
        step();
        chk("to_pulse_one_cycle", err_timeout, 0);
        rst_n = 0;
        step();
        rst_n = 1;
        s_mute = 0;
        cmp_en = 1;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
